csr_islem_birimi: RTL

- Execute-side CSR micro-op unit for Zicsr instructions (CSRRW/CSRRS/CSRRC and the immediate forms).
- Reads the CSR through the control-status unit's read port and reserves the CSR with the uop tag.
- Computes the new value, issues the tagged write, and returns the old value to writeback.
- Raises an illegal-instruction exception on the execute exception port when the access is not allowed.

---
 rtl/csr_islem_birimi.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/csr_islem_birimi.sv
// Execute-side Zicsr micro-op unit: reads and reserves a CSR, computes the new value,
// issues the tagged write and returns the old value to writeback.
//
// state  | meaning
// BOSTA  | idle, ready to accept a CSR uop
// BEKLE  | read port driven, waiting for the CSR to have no pending writer
// YAZ    | tagged write issued (restoring old value when flushed)
// SONUC  | old value held on the result port until writeback takes it
module csr_islem_birimi #(
  parameter int MXLEN         = 32,
  parameter int CSR_ADRES_BIT = 12,
  parameter int UOP_TAG_BIT   = 4,
  parameter int PS_BIT        = 32,
  parameter int EXC_CODE_BIT  = 5
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     uop_gecerli_i,
  output logic                     uop_hazir_o,
  input  logic [2:0]               uop_islem_i,
  input  logic [CSR_ADRES_BIT-1:0] uop_adres_i,
  input  logic [MXLEN-1:0]         uop_rs1_i,
  input  logic [4:0]               uop_uimm_i,
  input  logic                     uop_rs1_sifir_i,
  input  logic [UOP_TAG_BIT-1:0]   uop_etiket_i,
  input  logic [PS_BIT-1:0]        uop_ps_i,
  output logic [CSR_ADRES_BIT-1:0] oku_istek_adres_o,
  output logic [UOP_TAG_BIT-1:0]   oku_istek_etiket_o,
  output logic                     oku_istek_etiket_gecerli_o,
  input  logic [MXLEN-1:0]         csr_veri_i,
  input  logic                     csr_gecerli_i,
  output logic [MXLEN-1:0]         yaz_istek_veri_o,
  output logic [CSR_ADRES_BIT-1:0] yaz_istek_adres_o,
  output logic [UOP_TAG_BIT-1:0]   yaz_istek_etiket_o,
  output logic                     yaz_istek_gecerli_o,
  output logic [MXLEN-1:0]         sonuc_veri_o,
  output logic [UOP_TAG_BIT-1:0]   sonuc_etiket_o,
  output logic                     sonuc_gecerli_o,
  input  logic                     sonuc_hazir_i,
  output logic [PS_BIT-1:0]        yurut_odd_ps_o,
  output logic [EXC_CODE_BIT-1:0]  yurut_odd_kod_o,
  output logic [MXLEN-1:0]         yurut_odd_bilgi_o,
  output logic                     yurut_odd_gecerli_o,
  input  logic                     bosalt_i
);

  typedef enum logic [1:0] {BOSTA, BEKLE, YAZ, SONUC} durum_t;

  durum_t r_durum;
  durum_t w_durum_sonraki;

  logic [2:0]               r_islem;
  logic [CSR_ADRES_BIT-1:0] r_adres;
  logic [MXLEN-1:0]         r_rs1;
  logic [4:0]               r_uimm;
  logic                     r_rs1_sifir;
  logic [UOP_TAG_BIT-1:0]   r_etiket;
  logic [PS_BIT-1:0]        r_ps;
  logic [MXLEN-1:0]         r_eski;
  logic [MXLEN-1:0]         r_yeni;

  logic                     w_kabul;
  logic                     w_oku_tamam;
  logic                     w_yazma;
  logic                     w_yasadisi;
  logic [MXLEN-1:0]         w_kaynak;
  logic [MXLEN-1:0]         w_yeni;

  // Set/clear with a zero source never modify the CSR, so they must not count as writes
  // (this is what lets read-only CSRs be read with CSRRS x0).
  always_comb begin
    w_kaynak   = r_islem[2] ? {{(MXLEN-5){1'b0}}, r_uimm} : r_rs1;
    w_yazma    = !(r_islem[1] && r_rs1_sifir);
    w_yasadisi = (r_islem[1:0] == 2'b00) ||
                 (w_yazma && (r_adres[CSR_ADRES_BIT-1 -: 2] == 2'b11));
    case (r_islem[1:0])
      2'b01:   w_yeni = w_kaynak;
      2'b10:   w_yeni = csr_veri_i | w_kaynak;
      2'b11:   w_yeni = csr_veri_i & ~w_kaynak;
      default: w_yeni = csr_veri_i;
    endcase
  end

  always_comb begin
    w_durum_sonraki            = r_durum;
    w_kabul                    = 1'b0;
    w_oku_tamam                = 1'b0;
    uop_hazir_o                = 1'b0;
    oku_istek_adres_o          = '0;
    oku_istek_etiket_o         = '0;
    oku_istek_etiket_gecerli_o = 1'b0;
    yaz_istek_veri_o           = '0;
    yaz_istek_adres_o          = '0;
    yaz_istek_etiket_o         = '0;
    yaz_istek_gecerli_o        = 1'b0;
    sonuc_veri_o               = '0;
    sonuc_etiket_o             = '0;
    sonuc_gecerli_o            = 1'b0;
    yurut_odd_ps_o             = '0;
    yurut_odd_kod_o            = '0;
    yurut_odd_bilgi_o          = '0;
    yurut_odd_gecerli_o        = 1'b0;
    case (r_durum)
      BOSTA: begin
        uop_hazir_o = 1'b1;
        if (uop_gecerli_i && !bosalt_i) begin
          w_kabul         = 1'b1;
          w_durum_sonraki = BEKLE;
        end
      end
      BEKLE: begin
        oku_istek_adres_o = r_adres;
        if (bosalt_i) begin
          w_durum_sonraki = BOSTA;
        end else if (w_yasadisi) begin
          yurut_odd_gecerli_o = 1'b1;
          yurut_odd_kod_o     = EXC_CODE_BIT'(2);
          yurut_odd_ps_o      = r_ps;
          yurut_odd_bilgi_o   = {{(MXLEN-CSR_ADRES_BIT){1'b0}}, r_adres};
          w_durum_sonraki     = BOSTA;
        end else if (csr_gecerli_i) begin
          w_oku_tamam = 1'b1;
          if (w_yazma) begin
            oku_istek_etiket_o         = r_etiket;
            oku_istek_etiket_gecerli_o = 1'b1;
            w_durum_sonraki            = YAZ;
          end else begin
            w_durum_sonraki = SONUC;
          end
        end
      end
      YAZ: begin
        // A flushed write still goes out with the old value so the reservation is released.
        yaz_istek_gecerli_o = 1'b1;
        yaz_istek_adres_o   = r_adres;
        yaz_istek_etiket_o  = r_etiket;
        yaz_istek_veri_o    = bosalt_i ? r_eski : r_yeni;
        w_durum_sonraki     = bosalt_i ? BOSTA : SONUC;
      end
      SONUC: begin
        sonuc_gecerli_o = 1'b1;
        sonuc_veri_o    = r_eski;
        sonuc_etiket_o  = r_etiket;
        if (bosalt_i || sonuc_hazir_i) begin
          w_durum_sonraki = BOSTA;
        end
      end
      default: w_durum_sonraki = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_durum <= BOSTA;
    end else begin
      r_durum <= w_durum_sonraki;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_islem     <= '0;
      r_adres     <= '0;
      r_rs1       <= '0;
      r_uimm      <= '0;
      r_rs1_sifir <= 1'b0;
      r_etiket    <= '0;
      r_ps        <= '0;
      r_eski      <= '0;
      r_yeni      <= '0;
    end else begin
      if (w_kabul) begin
        r_islem     <= uop_islem_i;
        r_adres     <= uop_adres_i;
        r_rs1       <= uop_rs1_i;
        r_uimm      <= uop_uimm_i;
        r_rs1_sifir <= uop_rs1_sifir_i;
        r_etiket    <= uop_etiket_i;
        r_ps        <= uop_ps_i;
      end
      if (w_oku_tamam) begin
        r_eski <= csr_veri_i;
        r_yeni <= w_yeni;
      end
    end
  end

endmodule
